frac_clk_gen: RTL and testbench

//   Run-time programmable fractional clock generator: P/Q phase accumulator producing df at (P/Q)*f(clk).

---
 rtl/frac_clk_gen.sv | 141 ++++++++++++++
 tb/tb_frac_clk_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_clk_gen.sv
// frac_clk_gen: run-time programmable P/Q fractional clock generator.
// A phase accumulator adds 2*P each clock and subtracts Q on overflow. Each
// overflow toggles df, so df runs at (P/Q)*f(clk). Ratio updates go through
// a ready/valid shadow register and are applied to the live ratio only on a
// df rising edge, or straight away while idle. Stop is glitch-free: df
// always finishes its current high phase before the generator goes idle.
//
// Handshake: a config word is taken at a posedge where cfg_valid & cfg_ready.
// cfg_valid may be held across cycles. cfg_ready is registered (~shd_vld)
// and never depends combinationally on cfg_valid.
module frac_clk_gen #(
  parameter int QWID  = 16,
  parameter int CCWID = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [QWID-1:0]  cfg_p,
  input  logic [QWID-1:0]  cfg_q,
  output logic             cfg_err,
  output logic             busy,
  output logic             en,
  output logic             df,
  output logic [CCWID-1:0] cc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state, state_d;

  logic [QWID:0]    acc, acc_d, sum, q_ext;
  logic             df_d, en_d;
  logic [CCWID-1:0] cc_d;
  logic             toggle, xfer, accept, cfg_ok;

  logic [QWID-1:0]  shd_p, shd_q, act_p, act_q;
  logic             shd_vld, act_vld;

  assign cfg_ready = ~shd_vld;
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid & cfg_ready;
  // A ratio is usable only if Q is non-zero and the output does not exceed f/2.
  assign cfg_ok    = (cfg_q != '0) && ({cfg_p, 1'b0} <= {1'b0, cfg_q});

  // The sum cannot overflow QWID+1 bits: acc < Q and 2P <= Q.
  assign sum    = acc + {act_p, 1'b0};
  assign q_ext  = {1'b0, act_q};
  assign toggle = (sum >= q_ext);

  // Next state and next accumulator/output values.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    df_d    = df;
    en_d    = 1'b0;
    cc_d    = cc;
    case (state)
      IDLE: begin
        df_d = 1'b0;
        if (!stop && start && act_vld) begin
          state_d = RUN;
          acc_d   = '0;
          cc_d    = '0;
        end
      end
      RUN: begin
        if (toggle) begin
          acc_d = sum - q_ext;
          df_d  = ~df;
          en_d  = ~df;
          if (!df) cc_d = cc + 1'b1;
        end else begin
          acc_d = sum;
        end
        if (stop) state_d = (!df && !toggle) ? IDLE : STOP;
      end
      STOP: begin
        // Only a falling toggle is allowed here, so no en can occur. If df
        // already fell on the cycle stop was taken, leave at once.
        if (!df) begin
          state_d = IDLE;
        end else if (toggle) begin
          acc_d   = sum - q_ext;
          df_d    = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The shadow moves to the live ratio while idle, or on a df rising edge.
  assign xfer = (state == IDLE) ? shd_vld : en_d;

  // State register, generator outputs and the config shadow/live registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      df      <= 1'b0;
      en      <= 1'b0;
      cc      <= '0;
      cfg_err <= 1'b0;
      shd_p   <= '0;
      shd_q   <= '0;
      shd_vld <= 1'b0;
      act_p   <= '0;
      act_q   <= '0;
      act_vld <= 1'b0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      df      <= df_d;
      en      <= en_d;
      cc      <= cc_d;
      cfg_err <= accept & ~cfg_ok;
      if (accept && cfg_ok) begin
        shd_p   <= cfg_p;
        shd_q   <= cfg_q;
        shd_vld <= 1'b1;
      end else if (xfer) begin
        shd_vld <= 1'b0;
      end
      if (xfer) begin
        act_p   <= shd_p;
        act_q   <= shd_q;
        act_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// tb_frac_clk_gen: directed bench for frac_clk_gen. Expected values go into
// exp_q as each step is driven and are popped when the DUT output is sampled
// on the falling clock edge. The cc counter is built 4 bits wide so that the
// wrap can be reached in a short run.
module tb_frac_clk_gen;

  localparam int QW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [QW-1:0] cfg_p;
  logic [QW-1:0] cfg_q;
  logic          cfg_err;
  logic          busy;
  logic          en;
  logic          df;
  logic [CW-1:0] cc;

  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  frac_clk_gen #(.QWID(QW), .CCWID(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_p     (cfg_p),
    .cfg_q     (cfg_q),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .en        (en),
    .df        (df),
    .cc        (cc)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%0h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timed out observed=0 expected=1", tag);
  endtask

  // Offer one config word; waits for cfg_ready and checks cfg_err after accept.
  task automatic cfg(input logic [QW-1:0] p, input logic [QW-1:0] q, input logic err_e);
    int n;
    n = 0;
    cfg_p = p;
    cfg_q = q;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) timeout_fail("cfg_ready_wait");
    tick();
    cfg_valid = 1'b0;
    push_exp(32'(err_e));
    chk("cfg_err", 32'(cfg_err));
  endtask

  // Pulse start; returns at the negedge after the IDLE->RUN edge.
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n;
    n = 0;
    while (!en && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) timeout_fail(tag);
  endtask

  initial begin
    int en_cnt;
    int len;
    logic prev;
    logic phase_ok;

    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_valid = 1'b0;
    cfg_p = '0;
    cfg_q = '0;
    tick();
    tick();

    // Reset state.
    push_exp(0); chk("rst_df", 32'(df));
    push_exp(0); chk("rst_en", 32'(en));
    push_exp(0); chk("rst_cc", 32'(cc));
    push_exp(0); chk("rst_busy", 32'(busy));
    push_exp(1); chk("rst_cfg_ready", 32'(cfg_ready));
    push_exp(0); chk("rst_cfg_err", 32'(cfg_err));
    rst_n = 1'b1;
    tick();

    // start with no config loaded is ignored.
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    push_exp(0); chk("start_noconfig_busy", 32'(busy));

    // Test 1: p=1 q=4, period 4, first rise on the 2nd RUN edge.
    cfg(16'd1, 16'd4, 1'b0);
    push_exp(0); chk("t1_ready_after_accept", 32'(cfg_ready));
    tick();
    push_exp(1); chk("t1_ready_after_xfer", 32'(cfg_ready));
    go();
    push_exp(1); chk("t1_busy", 32'(busy));
    push_exp(0); chk("t1_df_k0", 32'(df));
    for (int k = 1; k <= 12; k++) begin
      tick();
      push_exp(32'((k >= 2) && (((k - 2) % 4) < 2))); chk("t1_df", 32'(df));
      push_exp(32'((k >= 2) && (((k - 2) % 4) == 0))); chk("t1_en", 32'(en));
      push_exp((k >= 2) ? 32'((k + 2) / 4) : 32'd0); chk("t1_cc", 32'(cc));
    end

    // Test 2: p=3 q=10 gives exactly 30 en in 100 RUN clocks, phases 1-2 clk.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cfg(16'd3, 16'd10, 1'b0);
    tick();
    go();
    en_cnt = 0;
    len = 0;
    prev = 1'b0;
    phase_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (en) en_cnt++;
      if (df != prev) begin
        if (len < 1 || len > 2) phase_ok = 1'b0;
        len = 1;
        prev = df;
      end else begin
        len++;
      end
    end
    push_exp(30); chk("t2_en_count", 32'(en_cnt));
    push_exp(1); chk("t2_phase_len_ok", 32'(phase_ok));

    // Test 3: live change 1/4 -> 1/8 offered in a high phase.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cfg(16'd1, 16'd4, 1'b0);
    tick();
    go();
    tick();
    tick();
    push_exp(1); chk("t3_df_k2", 32'(df));
    cfg_p = 16'd1;
    cfg_q = 16'd8;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    push_exp(0); chk("t3_cfg_err_k3", 32'(cfg_err));
    push_exp(0); chk("t3_ready_k3", 32'(cfg_ready));
    tick();
    push_exp(0); chk("t3_ready_k4", 32'(cfg_ready));
    push_exp(0); chk("t3_df_k4", 32'(df));
    tick();
    push_exp(0); chk("t3_ready_k5", 32'(cfg_ready));
    tick();
    push_exp(1); chk("t3_en_k6", 32'(en));
    push_exp(1); chk("t3_ready_k6", 32'(cfg_ready));
    for (int k = 7; k <= 14; k++) begin
      tick();
      push_exp(32'(k <= 9 || k == 14)); chk("t3_df_new", 32'(df));
      push_exp(32'(k == 14)); chk("t3_en_new", 32'(en));
    end

    // Test 4: invalid offers are rejected and leave the live ratio alone.
    push_exp(1); chk("t4_ready_before", 32'(cfg_ready));
    cfg(16'd5, 16'd8, 1'b1);
    push_exp(1); chk("t4_ready_after_bad1", 32'(cfg_ready));
    tick();
    push_exp(0); chk("t4_err_one_cycle", 32'(cfg_err));
    cfg(16'd1, 16'd0, 1'b1);
    tick();
    push_exp(1); chk("t4_ready_after_bad2", 32'(cfg_ready));
    en_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (en) en_cnt++;
    end
    push_exp(4); chk("t4_en_count_q8", 32'(en_cnt));

    // Test 5: stop during a high phase finishes the phase, then goes idle.
    wait_en("t5_wait_rise");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push_exp(1); chk("t5_busy_r1", 32'(busy));
    push_exp(1); chk("t5_df_r1", 32'(df));
    tick();
    push_exp(1); chk("t5_df_r2", 32'(df));
    push_exp(0); chk("t5_en_r2", 32'(en));
    tick();
    push_exp(1); chk("t5_df_r3", 32'(df));
    tick();
    push_exp(0); chk("t5_df_r4", 32'(df));
    push_exp(0); chk("t5_busy_r4", 32'(busy));
    for (int k = 0; k < 6; k++) begin
      tick();
      push_exp(0); chk("t5_df_idle", 32'(df));
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    push_exp(0); chk("t5_start_stop_idle", 32'(busy));
    go();
    push_exp(1); chk("t5_restart_busy", 32'(busy));

    // Test 6: asynchronous reset mid-RUN.
    wait_en("t6_wait_rise");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(0); chk("t6_df_async", 32'(df));
    push_exp(0); chk("t6_en_async", 32'(en));
    push_exp(0); chk("t6_cc_async", 32'(cc));
    push_exp(0); chk("t6_busy_async", 32'(busy));
    push_exp(1); chk("t6_ready_async", 32'(cfg_ready));
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    push_exp(0); chk("t6_start_ignored", 32'(busy));

    // Boundary: 2P==Q toggles every clock; cc wraps after 16 rises.
    cfg(16'd2, 16'd4, 1'b0);
    tick();
    go();
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k <= 6) begin
        push_exp(32'(k % 2)); chk("b_df", 32'(df));
        push_exp(32'(k % 2)); chk("b_en", 32'(en));
      end
      if (k == 29) begin
        push_exp(15); chk("b_cc_max", 32'(cc));
      end
      if (k == 31) begin
        push_exp(0); chk("b_cc_wrap", 32'(cc));
      end
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL leftover_expectations: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
